pooling_controller: RTL and testbench

Sequencer for one shared `mean_pooling` unit. It walks a feature map stored in a single-port memory in 2x2, stride-2 windows. For each window it gathers the four elements, hands them to the pooling unit with an `input_ready` pulse, waits for `done`, and writes the result to an output map. It sits between the layer scheduler (`start`/`done`) and the pooling datapath plus the activation memory.

---
 rtl/pooling_pkg.sv | 11 +
 rtl/pool_addr_gen.sv | 48 ++++
 rtl/pooling_controller.sv | 107 ++++++++++
 tb/tb_pooling_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pooling_pkg.sv
// Shared types and fixed-point sizing for the pooling sequencer.
package pooling_pkg;
  localparam int IL   = 4;
  localparam int FL   = 16;
  localparam int DW   = IL + FL;
  localparam int size = 4;

  typedef logic [DW-1:0] fx_t;

  typedef enum logic [2:0] {IDLE, FETCH, LAUNCH, WAIT, WRITE, FIN} pool_ctrl_state_t;
endpackage

// File: rtl/pool_addr_gen.sv
// Window counters plus read/write address generation for 2x2 stride-2 pooling.
module pool_addr_gen #(
  parameter int DIM_W  = 7,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [1:0]        k,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last_window
);
  logic [DIM_W-1:0]  width, ow, oh, wr, wc;
  logic [ADDR_W-1:0] ib, ob;

  always_ff @(posedge clk) begin
    if (rst) begin
      width <= '0; ow <= '0; oh <= '0; wr <= '0; wc <= '0;
      ib <= '0; ob <= '0;
    end else if (load) begin
      width <= cfg_width;
      ow    <= cfg_width >> 1;
      oh    <= cfg_height >> 1;
      ib    <= in_base;
      ob    <= out_base;
      wr    <= '0;
      wc    <= '0;
    end else if (advance) begin
      if (wc == ow - DIM_W'(1)) begin
        wc <= '0;
        wr <= wr + DIM_W'(1);
      end else begin
        wc <= wc + DIM_W'(1);
      end
    end
  end

  // k[1] selects the lower row of the window, k[0] the right column
  assign rd_addr = ib + ADDR_W'({wr, k[1]}) * ADDR_W'(width) + ADDR_W'({wc, k[0]});
  assign wr_addr = ob + ADDR_W'(wr) * ADDR_W'(ow) + ADDR_W'(wc);
  assign last_window = (wr == oh - DIM_W'(1)) && (wc == ow - DIM_W'(1));
endmodule

// File: rtl/pooling_controller.sv
// Sequences 2x2 windows from activation memory through a shared mean-pooling unit.
module pooling_controller #(
  parameter int IL     = 4,
  parameter int FL     = 16,
  parameter int size   = 4,
  parameter int DIM_W  = 7,
  parameter int ADDR_W = 16,
  localparam int DW    = IL + FL
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DIM_W-1:0]         cfg_width,
  input  logic [DIM_W-1:0]         cfg_height,
  input  logic [ADDR_W-1:0]        in_base,
  input  logic [ADDR_W-1:0]        out_base,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic [DW-1:0]            mem_rd_data,
  output logic [size-1:0][DW-1:0]  pool_im,
  output logic                     pool_en,
  output logic                     pool_input_ready,
  input  logic [DW-1:0]            pool_om,
  input  logic                     pool_done,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DW-1:0]            wr_data
);
  import pooling_pkg::*;

  pool_ctrl_state_t state, next;
  logic [2:0] fcnt;
  logic [1:0] cap_idx;
  logic       armed, load, advance, last_window;

  pool_addr_gen #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_addr (
    .clk(clk), .rst(rst), .load(load), .advance(advance), .k(fcnt[1:0]),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_base(in_base), .out_base(out_base),
    .rd_addr(mem_rd_addr), .wr_addr(wr_addr), .last_window(last_window)
  );

  // data for read k arrives while fcnt == k+1
  assign cap_idx = fcnt[1:0] - 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      fcnt    <= '0;
      armed   <= 1'b0;
      pool_im <= '0;
      wr_data <= '0;
    end else begin
      state <= next;
      if (state == FETCH) begin
        fcnt <= fcnt + 3'd1;
        if (fcnt != 3'd0) pool_im[cap_idx] <= mem_rd_data;
      end else begin
        fcnt <= '0;
      end
      // a done level left over from the previous window must drop before it counts
      if (state == LAUNCH) armed <= !pool_done;
      else if (state == WAIT && !pool_done) armed <= 1'b1;
      if (state == WAIT && armed && pool_done) wr_data <= pool_om;
    end
  end

  always_comb begin
    next             = state;
    mem_rd_en        = 1'b0;
    pool_input_ready = 1'b0;
    wr_en            = 1'b0;
    done             = 1'b0;
    load             = 1'b0;
    advance          = 1'b0;
    case (state)
      IDLE: if (start) begin
        load = 1'b1;
        next = (cfg_width[DIM_W-1:1] == '0 || cfg_height[DIM_W-1:1] == '0) ? FIN : FETCH;
      end
      FETCH: begin
        mem_rd_en = !fcnt[2];
        if (fcnt == 3'd4) next = LAUNCH;
      end
      LAUNCH: begin
        pool_input_ready = 1'b1;
        next = WAIT;
      end
      WAIT: if (armed && pool_done) next = WRITE;
      WRITE: begin
        wr_en   = 1'b1;
        advance = 1'b1;
        next    = last_window ? FIN : FETCH;
      end
      FIN: begin
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign pool_en = busy;
endmodule

// File: tb/tb_pooling_controller.sv
// Directed table-driven bench for pooling_controller with memory and pooling-unit stubs.
module tb_pooling_controller;
  logic              clk = 1'b0;
  logic              rst, start;
  logic [6:0]        cfg_width, cfg_height;
  logic [15:0]       in_base, out_base;
  logic              busy, done, mem_rd_en, pool_en, pool_input_ready, wr_en, pool_done;
  logic [15:0]       mem_rd_addr, wr_addr;
  logic [19:0]       mem_rd_data, pool_om, wr_data;
  logic [3:0][19:0]  pool_im;

  pooling_controller dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_base(in_base), .out_base(out_base), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .pool_im(pool_im), .pool_en(pool_en), .pool_input_ready(pool_input_ready),
    .pool_om(pool_om), .pool_done(pool_done), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // memory stub: one-cycle read latency
  logic [19:0] mem [256];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[7:0]];

  // pooling stub: mean of four, done three cycles after input_ready; level mode holds done
  logic        level_mode;
  logic [1:0]  scnt;
  logic [19:0] sres;
  logic [21:0] ssum;
  assign ssum = {2'b0, pool_im[0]} + {2'b0, pool_im[1]} + {2'b0, pool_im[2]} + {2'b0, pool_im[3]};
  always @(posedge clk) begin
    if (rst) begin
      scnt <= 2'd0; pool_done <= 1'b0; pool_om <= '0; sres <= '0;
    end else if (pool_input_ready) begin
      sres <= ssum[21:2]; scnt <= 2'd1;
      if (!level_mode) pool_done <= 1'b0;
    end else if (scnt == 2'd1) begin
      scnt <= 2'd2; pool_done <= 1'b0;
    end else if (scnt == 2'd2) begin
      scnt <= 2'd0; pool_done <= 1'b1; pool_om <= sres;
    end else if (!level_mode) begin
      pool_done <= 1'b0;
    end
  end

  // monitor, sampled 1 time unit after each rising edge
  int cyc = 0, start_cyc, done_cyc, first_rd, done_cnt, rdy_cnt, overlap, enbusy_err;
  logic [15:0] rd_q[$];
  logic [15:0] wa_q[$];
  logic [19:0] wd_q[$];
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (mem_rd_en === 1'b1) begin
      rd_q.push_back(mem_rd_addr);
      if (first_rd < 0) first_rd = cyc;
    end
    if (wr_en === 1'b1) begin wa_q.push_back(wr_addr); wd_q.push_back(wr_data); end
    if (pool_input_ready === 1'b1) rdy_cnt++;
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (mem_rd_en === 1'b1 && wr_en === 1'b1) overlap++;
    if (pool_en !== busy) enbusy_err++;
  end

  int errors = 0, checks = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_logs();
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    first_rd = -1; done_cnt = 0; rdy_cnt = 0; overlap = 0; enbusy_err = 0; done_cyc = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_ready"}, pool_input_ready, 0);
    chk({tag, "_pool_en"}, pool_en, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_rd_addr"}, mem_rd_addr, 0);
    chk({tag, "_pool_im_nz"}, (pool_im != '0), 0);
  endtask

  typedef struct {
    logic [6:0]        w, h;
    logic [15:0]       ib, ob;
    bit                level;
    int                nwin, span;
    logic [3:0][15:0]  wa;
    logic [3:0][19:0]  wd;
  } vec_t;
  vec_t tbl[5];

  task automatic load_mem(input int id);
    for (int a = 0; a < 256; a++) mem[a] = '0;
    case (id)
      0: begin mem[0] = 20'd520; mem[1] = 20'd360; mem[2] = 20'd1378; mem[3] = 20'd280; end
      1, 4: for (int a = 0; a < 16; a++) mem[a] = 20'(a);
      2: for (int a = 0; a < 15; a++) mem[a] = 20'(a * 4);
      default: ;
    endcase
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (done_cnt == 0 && n < lim) begin @(negedge clk); n++; end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic kick(input logic [6:0] w, input logic [6:0] h, input logic [15:0] ib,
                      input logic [15:0] ob);
    @(negedge clk);
    cfg_width = w; cfg_height = h; in_base = ib; out_base = ob;
    start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // scenario table: 2x2, 4x4, 5x3 odd, 1x4 degenerate, 4x4 with level done
    tbl[0] = '{w:7'd2, h:7'd2, ib:16'd0, ob:16'd100, level:1'b0, nwin:1, span:12, wa:'0, wd:'0};
    tbl[0].wa[0] = 16'd100; tbl[0].wd[0] = 20'd634;
    tbl[1] = '{w:7'd4, h:7'd4, ib:16'd0, ob:16'd64, level:1'b0, nwin:4, span:42, wa:'0, wd:'0};
    tbl[2] = '{w:7'd5, h:7'd3, ib:16'd0, ob:16'd200, level:1'b0, nwin:2, span:22, wa:'0, wd:'0};
    tbl[2].wa[0] = 16'd200; tbl[2].wd[0] = 20'd12;
    tbl[2].wa[1] = 16'd201; tbl[2].wd[1] = 20'd20;
    tbl[3] = '{w:7'd1, h:7'd4, ib:16'd0, ob:16'd30, level:1'b0, nwin:0, span:2, wa:'0, wd:'0};
    tbl[4] = '{w:7'd4, h:7'd4, ib:16'd0, ob:16'd64, level:1'b1, nwin:4, span:42, wa:'0, wd:'0};
    for (int j = 0; j < 4; j++) begin
      tbl[1].wa[j] = 16'(64 + j); tbl[4].wa[j] = 16'(64 + j);
    end
    tbl[1].wd[0] = 20'd2; tbl[1].wd[1] = 20'd4; tbl[1].wd[2] = 20'd10; tbl[1].wd[3] = 20'd12;
    tbl[4].wd = tbl[1].wd;

    rst = 1'b1; start = 1'b0; level_mode = 1'b0;
    cfg_width = '0; cfg_height = '0; in_base = '0; out_base = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      int ow, oh, idx, forb;
      load_mem(i); level_mode = tbl[i].level;
      @(negedge clk);
      clear_logs();
      kick(tbl[i].w, tbl[i].h, tbl[i].ib, tbl[i].ob);
      chk($sformatf("s%0d_busy_after_start", i), busy, 1);
      wait_done(600);
      repeat (4) @(negedge clk);
      chk($sformatf("s%0d_done_cnt", i), done_cnt, 1);
      chk($sformatf("s%0d_span", i), done_cyc - start_cyc + 1, tbl[i].span);
      chk($sformatf("s%0d_writes", i), wa_q.size(), tbl[i].nwin);
      chk($sformatf("s%0d_ready_pulses", i), rdy_cnt, tbl[i].nwin);
      chk($sformatf("s%0d_reads", i), rd_q.size(), 4 * tbl[i].nwin);
      chk($sformatf("s%0d_rd_wr_overlap", i), overlap, 0);
      chk($sformatf("s%0d_pool_en_vs_busy", i), enbusy_err, 0);
      for (int j = 0; j < tbl[i].nwin && j < wa_q.size(); j++) begin
        chk($sformatf("s%0d_wr_addr%0d", i, j), wa_q[j], tbl[i].wa[j]);
        chk($sformatf("s%0d_wr_data%0d", i, j), wd_q[j], tbl[i].wd[j]);
      end
      if (tbl[i].nwin > 0) chk($sformatf("s%0d_first_read_lat", i), first_rd - start_cyc, 1);
      ow = int'(tbl[i].w) / 2; oh = int'(tbl[i].h) / 2; idx = 0;
      for (int r = 0; r < oh; r++)
        for (int c = 0; c < ow; c++)
          for (int k = 0; k < 4; k++) begin
            if (idx < rd_q.size())
              chk($sformatf("s%0d_rd_addr%0d", i, idx), rd_q[idx],
                  int'(tbl[i].ib) + (2 * r + k / 2) * int'(tbl[i].w) + 2 * c + k % 2);
            idx++;
          end
      if (i == 2) begin
        forb = 0;
        foreach (rd_q[q]) if (rd_q[q] % 5 == 4 || rd_q[q] >= 10) forb++;
        chk("s2_col4_row2_reads", forb, 0);
      end
    end

    // reset during the second window's WAIT
    level_mode = 1'b0;
    load_mem(1);
    @(negedge clk);
    clear_logs();
    kick(7'd4, 7'd4, 16'd0, 16'd64);
    begin
      int n = 0;
      while (rdy_cnt < 2 && n < 200) begin @(negedge clk); n++; end
      chk("rst_reached_window2", rdy_cnt, 2);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_writes", wa_q.size(), 1);
    chk("midrst_done", done_cnt, 0);

    // start while busy is ignored, config changes after start are harmless
    load_mem(0);
    @(negedge clk);
    clear_logs();
    kick(7'd2, 7'd2, 16'd0, 16'd100);
    @(negedge clk);
    cfg_width = 7'd8; cfg_height = 7'd8; in_base = 16'd50; out_base = 16'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    repeat (6) @(negedge clk);
    chk("ign_done_cnt", done_cnt, 1);
    chk("ign_span", done_cyc - start_cyc + 1, 12);
    chk("ign_writes", wa_q.size(), 1);
    chk("ign_reads", rd_q.size(), 4);
    if (wa_q.size() > 0) begin
      chk("ign_wr_addr", wa_q[0], 100);
      chk("ign_wr_data", wd_q[0], 634);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
